// File: rtl/fpu_cmp_pkg.sv
// Shared types and helpers for the pipelined floating-point compare / min-max unit.
// Holds the opcode encoding, the per-operand class record and the canonical NaN pattern.
package fpu_cmp_pkg;

  typedef enum logic [2:0] {
    OP_FLE  = 3'b000,
    OP_FLT  = 3'b001,
    OP_FEQ  = 3'b010,
    OP_FMIN = 3'b100,
    OP_FMAX = 3'b101
  } fpu_cmp_op_e;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
    logic sign;
  } fp_class_t;

  // Quiet NaN with clear sign and payload, right-aligned in 64 bits
  function automatic logic [63:0] canonical_nan(input int unsigned exp_w, input int unsigned man_w);
    canonical_nan = ((64'd1 << (exp_w + 32'd1)) - 64'd1) << (man_w - 32'd1);
  endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational IEEE-754 operand classifier: zero / infinity / NaN / signaling NaN / sign.
// Denormals are reported as ordinary finite values.
module fpu_classify
  import fpu_cmp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] val_i,
  output fp_class_t            cls_o
);

  logic [EXP_W-1:0] exp_s;
  logic [MAN_W-1:0] man_s;
  logic             exp_ones_s;
  logic             exp_zero_s;
  logic             man_zero_s;

  assign exp_s = val_i[EXP_W+MAN_W-1:MAN_W];
  assign man_s = val_i[MAN_W-1:0];

  // Decode the exponent/mantissa fields into class flags
  always_comb begin
    exp_ones_s = &exp_s;
    exp_zero_s = ~|exp_s;
    man_zero_s = ~|man_s;
    cls_o      = '0;
    cls_o.sign = val_i[EXP_W+MAN_W];
    cls_o.zero = exp_zero_s & man_zero_s;
    cls_o.inf  = exp_ones_s & man_zero_s;
    cls_o.nan  = exp_ones_s & ~man_zero_s;
    cls_o.snan = exp_ones_s & ~man_zero_s & ~man_s[MAN_W-1];
  end

endmodule

// File: rtl/fpu_cmp_pipe.sv
// Pipelined FEQ/FLT/FLE/FMIN/FMAX unit with RISC-V NaN, signed-zero and NV semantics.
// All arithmetic sits ahead of stage 1; later stages are valid/ready register slices.
module fpu_cmp_pipe
  import fpu_cmp_pkg::*;
#(
  parameter int unsigned EXP_W       = 8,
  parameter int unsigned MAN_W       = 23,
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [2:0]                 op_i,
  input  logic [EXP_W+MAN_W:0]       rs1_i,
  input  logic [EXP_W+MAN_W:0]       rs2_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [EXP_W+MAN_W:0]       result_o,
  output logic                       nv_o,
  output logic [TAG_W-1:0]           tag_o
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned LAST   = PIPE_STAGES - 1;
  localparam logic [63:0] CNAN64 = canonical_nan(EXP_W, MAN_W);

  typedef struct packed {
    logic [W-1:0]     result;
    logic             nv;
    logic [TAG_W-1:0] tag;
  } stage_t;

  fp_class_t    cls_a_s;
  fp_class_t    cls_b_s;
  logic [W-2:0] mag_a_s;
  logic [W-2:0] mag_b_s;
  logic         lt_s;
  logic         eq_s;
  logic         any_nan_s;
  logic         any_snan_s;
  logic         a_first_s;
  stage_t       calc_s;
  logic         unused_s;

  fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.val_i(rs1_i), .cls_o(cls_a_s));
  fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.val_i(rs2_i), .cls_o(cls_b_s));

  assign mag_a_s  = rs1_i[W-2:0];
  assign mag_b_s  = rs2_i[W-2:0];
  assign unused_s = ^{cls_a_s.inf, cls_b_s.inf};

  // Ordering, result selection and invalid flag for the offered operation
  always_comb begin
    lt_s       = 1'b0;
    eq_s       = 1'b0;
    calc_s     = '0;
    calc_s.tag = tag_i;
    any_nan_s  = cls_a_s.nan | cls_b_s.nan;
    any_snan_s = cls_a_s.snan | cls_b_s.snan;
    if (cls_a_s.zero && cls_b_s.zero) begin
      eq_s = 1'b1;
    end else if (cls_a_s.sign != cls_b_s.sign) begin
      lt_s = cls_a_s.sign;
    end else if (!cls_a_s.sign) begin
      lt_s = (mag_a_s < mag_b_s);
      eq_s = (mag_a_s == mag_b_s);
    end else begin
      lt_s = (mag_a_s > mag_b_s);
      eq_s = (mag_a_s == mag_b_s);
    end
    // min/max additionally orders -0 below +0
    a_first_s = lt_s | (cls_a_s.zero & cls_b_s.zero & cls_a_s.sign & ~cls_b_s.sign);
    case (op_i)
      OP_FLE: begin
        calc_s.result = {{(W-1){1'b0}}, ~any_nan_s & (lt_s | eq_s)};
        calc_s.nv     = any_nan_s;
      end
      OP_FLT: begin
        calc_s.result = {{(W-1){1'b0}}, ~any_nan_s & lt_s};
        calc_s.nv     = any_nan_s;
      end
      OP_FEQ: begin
        calc_s.result = {{(W-1){1'b0}}, ~any_nan_s & eq_s};
        calc_s.nv     = any_snan_s;
      end
      OP_FMIN, OP_FMAX: begin
        calc_s.nv = any_snan_s;
        if (cls_a_s.nan && cls_b_s.nan) begin
          calc_s.result = CNAN64[W-1:0];
        end else if (cls_a_s.nan) begin
          calc_s.result = rs2_i;
        end else if (cls_b_s.nan) begin
          calc_s.result = rs1_i;
        end else if ((op_i == OP_FMIN) == a_first_s) begin
          calc_s.result = rs1_i;
        end else begin
          calc_s.result = rs2_i;
        end
      end
      default: begin
        calc_s.result = '0;
        calc_s.nv     = 1'b0;
      end
    endcase
  end

  logic   stg_valid_s  [PIPE_STAGES];
  stage_t stg_data_s   [PIPE_STAGES];
  logic   load_s       [PIPE_STAGES];
  logic   prev_valid_s [PIPE_STAGES];
  stage_t prev_data_s  [PIPE_STAGES];

  // Backpressure chain: a stage may load when empty or when its content moves on
  always_comb begin
    for (int k = 0; k < PIPE_STAGES; k++) begin
      load_s[k] = 1'b0;
    end
    load_s[LAST] = !stg_valid_s[LAST] || out_ready_i;
    for (int k = int'(LAST) - 1; k >= 0; k--) begin
      load_s[k] = !stg_valid_s[k] || load_s[k+1];
    end
  end

  // Upstream source of each stage
  always_comb begin
    prev_valid_s[0] = in_valid_i;
    prev_data_s[0]  = calc_s;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      prev_valid_s[k] = stg_valid_s[k-1];
      prev_data_s[k]  = stg_data_s[k-1];
    end
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic   valid_r;
    stage_t data_r;

    // Occupancy flag; flush kills everything including the op accepted this cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_r <= 1'b0;
      end else if (flush_i) begin
        valid_r <= 1'b0;
      end else if (load_s[k]) begin
        valid_r <= prev_valid_s[k];
      end else begin
        valid_r <= valid_r;
      end
    end

    // Payload only changes when a real operation arrives, so held outputs stay stable
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_r <= '0;
      end else if (load_s[k] && prev_valid_s[k]) begin
        data_r <= prev_data_s[k];
      end else begin
        data_r <= data_r;
      end
    end

    assign stg_valid_s[k] = valid_r;
    assign stg_data_s[k]  = data_r;
  end

  assign in_ready_o  = load_s[0];
  assign out_valid_o = stg_valid_s[LAST];
  assign result_o    = stg_data_s[LAST].result;
  assign nv_o        = stg_data_s[LAST].nv;
  assign tag_o       = stg_data_s[LAST].tag;

endmodule
